// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared constants and helpers for the 16-channel PWM peripheral.
//   NUM_CH      : number of output channels
//   PWM_CNT_MAX : last value of the 8-bit PWM counter (period = 255 ticks)
//   DUTY_FULL   : duty value that forces a constant-high level
//   pwm_level() : compare function producing the shared PWM level
// ---------------------------------------------------------------------------
package pwm_pkg;

   localparam int         NUM_CH      = 16;
   localparam logic [7:0] PWM_CNT_MAX = 8'd254;
   localparam logic [7:0] DUTY_FULL   = 8'hFF;

   typedef logic [NUM_CH-1:0] ch_vec_t;

   // 0xFF is special-cased so that full duty never drops low: the counter
   // only reaches 254, so a plain compare would already hold high, but the
   // explicit term keeps the intent obvious and robust to counter changes.
   function automatic logic pwm_level(input logic [7:0] cnt,
                                      input logic [7:0] duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// ---------------------------------------------------------------------------
// pwm_timebase
// Shared timebase for all PWM channels: clock prescaler, 8-bit PWM counter,
// period wrap detection and the period_start pulse.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   pwm_cnt      : current PWM counter value (0..254)
//   wrap         : high during the clock whose rising edge wraps 254 -> 0
//   period_start : one-clk pulse, one clock after the wrap edge, aligned with
//                  the registered channel outputs showing pwm_cnt = 0
// ---------------------------------------------------------------------------
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 3000
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] pwm_cnt,
   output logic       wrap,
   output logic       period_start
);

   localparam int                 PRESC_W    = $clog2(CLK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

   logic [PRESC_W-1:0] presc;
   logic               tick;
   logic               wrap_p1;

   assign tick = (presc == PRESC_LAST);
   assign wrap = tick && (pwm_cnt == PWM_CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc        <= '0;
         pwm_cnt      <= '0;
         wrap_p1      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         if (tick) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end

         if (tick) begin
            if (pwm_cnt == PWM_CNT_MAX) begin
               pwm_cnt <= '0;
            end else begin
               pwm_cnt <= pwm_cnt + 8'd1;
            end
         end

         // --- stage p1: wrap edge seen; outputs register pwm_cnt = 0 next ---
         wrap_p1      <= wrap;
         // --- stage p2: pulse lines up with the registered outputs ---
         period_start <= wrap_p1;
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// ---------------------------------------------------------------------------
// pwm_peripheral
// 16-channel PWM / static output peripheral sharing one timebase and one
// duty value. Each channel is off, static high, or PWM driven.
// Ports:
//   clk                : system clock
//   rst_n              : asynchronous active-low reset
//   en_reg_out_7_0     : output enable, channels 7..0
//   en_reg_out_15_8    : output enable, channels 15..8
//   en_reg_pwm_7_0     : PWM mode select, channels 7..0
//   en_reg_pwm_15_8    : PWM mode select, channels 15..8
//   pwm_duty_cycle     : shared duty (0x00 = off, 0xFF = always on)
//   out                : registered channel outputs
//   period_start       : one-clk pulse at the start of each PWM period
// ---------------------------------------------------------------------------
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = 3000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   logic [7:0] pwm_cnt;
   logic       wrap;
   logic [7:0] duty_shadow;
   ch_vec_t    en_out;
   ch_vec_t    en_pwm;
   logic       level_p0;

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_cnt      (pwm_cnt),
      .wrap         (wrap),
      .period_start (period_start)
   );

   assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
   assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
   assign level_p0 = pwm_level(pwm_cnt, duty_shadow);

   // Duty is only sampled at the period wrap so a period is never split
   // between two duty values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_shadow <= 8'h00;
      end else if (wrap) begin
         duty_shadow <= pwm_duty_cycle;
      end
   end

   // --- stage p1: registered channel mux (enable gates PWM select) ---
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= en_out & (~en_pwm | {NUM_CH{level_p0}});
      end
   end

endmodule

// File: tb/tb_pwm_peripheral.sv
module tb_pwm_peripheral;

   localparam int CLK_DIV = 4;
   localparam int PERIOD  = 255 * CLK_DIV;   // 1020 clks

   logic        clk;
   logic        rst_n;
   logic [7:0]  en_reg_out_7_0;
   logic [7:0]  en_reg_out_15_8;
   logic [7:0]  en_reg_pwm_7_0;
   logic [7:0]  en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out;
   logic        period_start;

   int checks   = 0;
   int failures = 0;

   pwm_peripheral #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (out),
      .period_start    (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
      en_reg_out_7_0  = eo[7:0];
      en_reg_out_15_8 = eo[15:8];
      en_reg_pwm_7_0  = ep[7:0];
      en_reg_pwm_15_8 = ep[15:8];
   endtask

   // Bounded wait; leaves the bench on the sample where period_start is high.
   task automatic wait_period_start(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < PERIOD + 80; i++) begin
         step();
         if (period_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (ok !== 1'b1) begin
         failures++;
         $display("FAIL %s_ps_timeout observed=no_pulse required=pulse", name);
      end
   endtask

   // Walks one full period starting on the period_start sample. Expected
   // shape: all 16 outputs high for the first exp_high clks, low afterwards.
   // Optionally changes the duty input after sample chg_at.
   task automatic measure_period(input int exp_high, input int chg_at,
                                 input logic [7:0] chg_val,
                                 output int bad, output int ps_bad);
      logic [15:0] exp;
      bad    = 0;
      ps_bad = 0;
      for (int i = 0; i < PERIOD; i++) begin
         exp = (i < exp_high) ? 16'hFFFF : 16'h0000;
         if (out !== exp) bad++;
         if (i == 0) begin
            if (period_start !== 1'b1) ps_bad++;
         end else begin
            if (period_start !== 1'b0) ps_bad++;
         end
         if (i == chg_at) pwm_duty_cycle = chg_val;
         step();
      end
      if (period_start !== 1'b1) ps_bad++;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out !== 16'h0000) begin
         failures++;
         $display("FAIL reset_out observed=%h required=0000", out);
      end
      checks++;
      if (period_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_ps observed=%b required=0", period_start);
      end
      step();
      step();
      rst_n = 1'b1;
      set_en(16'hFFFF, 16'h0000);
      checks++;
      if (out !== 16'h0000) begin
         failures++;
         $display("FAIL en_same_cycle observed=%h required=0000", out);
      end
      step();
      checks++;
      if (out !== 16'hFFFF) begin
         failures++;
         $display("FAIL en_static_all observed=%h required=ffff", out);
      end
      set_en(16'h00FF, 16'h0000);
      step();
      checks++;
      if (out !== 16'h00FF) begin
         failures++;
         $display("FAIL en_static_low observed=%h required=00ff", out);
      end
   endtask

   task automatic test_duty_half();
      int bad, psb;
      set_en(16'hFFFF, 16'hFFFF);
      pwm_duty_cycle = 8'h80;
      wait_period_start("half");
      measure_period(512, -1, 8'h00, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL duty80_shape bad_samples=%0d required=0", bad);
      end
      checks++;
      if (psb != 0) begin
         failures++;
         $display("FAIL duty80_period_start bad_samples=%0d required=0", psb);
      end
   endtask

   task automatic test_duty_zero();
      int bad, psb;
      pwm_duty_cycle = 8'h00;
      measure_period(512, -1, 8'h00, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL zero_old_period bad_samples=%0d required=0", bad);
      end
      measure_period(0, -1, 8'h00, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL zero_low bad_samples=%0d required=0", bad);
      end
      checks++;
      if (psb != 0) begin
         failures++;
         $display("FAIL zero_period_start bad_samples=%0d required=0", psb);
      end
   endtask

   task automatic test_duty_full();
      int bad, psb;
      pwm_duty_cycle = 8'hFF;
      measure_period(0, -1, 8'h00, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL full_old_period bad_samples=%0d required=0", bad);
      end
      measure_period(PERIOD, -1, 8'h00, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL full_high bad_samples=%0d required=0", bad);
      end
      // Second all-high period spans the wrap; preload 0x40 mid-period.
      measure_period(PERIOD, 500, 8'h40, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL full_wrap_glitch bad_samples=%0d required=0", bad);
      end
      checks++;
      if (psb != 0) begin
         failures++;
         $display("FAIL full_period_start bad_samples=%0d required=0", psb);
      end
   endtask

   task automatic test_duty_change();
      int bad, psb;
      // Sample 40 corresponds to pwm_cnt = 10.
      measure_period(256, 40, 8'hC0, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL change_current bad_samples=%0d required=0", bad);
      end
      measure_period(768, -1, 8'h00, bad, psb);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL change_next bad_samples=%0d required=0", bad);
      end
      checks++;
      if (psb != 0) begin
         failures++;
         $display("FAIL change_period_start bad_samples=%0d required=0", psb);
      end
   endtask

   task automatic test_reset_mid_period();
      int k, low_bad;
      for (int i = 0; i < 400; i++) step();
      checks++;
      if (out !== 16'hFFFF) begin
         failures++;
         $display("FAIL midrst_before observed=%h required=ffff", out);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out !== 16'h0000) begin
         failures++;
         $display("FAIL midrst_async_out observed=%h required=0000", out);
      end
      step();
      step();
      checks++;
      if (period_start !== 1'b0 || out !== 16'h0000) begin
         failures++;
         $display("FAIL midrst_hold observed=%h/%b required=0000/0", out, period_start);
      end
      rst_n = 1'b1;
      k = 0;
      low_bad = 0;
      for (int i = 1; i <= PERIOD + 80; i++) begin
         step();
         if (period_start === 1'b1) begin
            k = i;
            break;
         end
         if (out !== 16'h0000) low_bad++;
      end
      checks++;
      if (k != PERIOD + 1) begin
         failures++;
         $display("FAIL midrst_first_ps observed_edge=%0d required_edge=%0d", k, PERIOD + 1);
      end
      checks++;
      if (low_bad != 0) begin
         failures++;
         $display("FAIL midrst_low_until_reload bad_samples=%0d required=0", low_bad);
      end
      checks++;
      if (out !== 16'hFFFF) begin
         failures++;
         $display("FAIL midrst_reload observed=%h required=ffff", out);
      end
   endtask

   task automatic test_mask();
      int bad;
      set_en(16'h0001, 16'h0002);
      pwm_duty_cycle = 8'h00;
      bad = 0;
      step();
      for (int i = 0; i < 2 * PERIOD + 100; i++) begin
         if (out !== 16'h0001) bad++;
         if (i == PERIOD) pwm_duty_cycle = 8'hFF;
         step();
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mask_static bad_samples=%0d required=0", bad);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      pwm_duty_cycle = 8'h00;
      set_en(16'h0000, 16'h0000);
      test_reset();
      test_duty_half();
      test_duty_zero();
      test_duty_full();
      test_duty_change();
      test_reset_mid_period();
      test_mask();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
